// File: rtl/alu_seq_pkg.sv
// Shared types and instruction-format constants for the alu_seq micro-sequencer.
// Field accessors keep the bit positions in one place.
package alu_seq_pkg;

    localparam int INSTR_W = 16;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 14;
    localparam int RD_MSB  = 13;
    localparam int RD_LSB  = 12;
    localparam int RS_MSB  = 11;
    localparam int RS_LSB  = 10;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic ALU_OP_ADD = 1'b1;

    typedef enum logic [1:0] {
        OP_LDI  = 2'b00,
        OP_ADD  = 2'b01,
        OP_JZ   = 2'b10,
        OP_HALT = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DECODE = 2'd2,
        S_EXEC   = 2'd3
    } state_e;

    function automatic opcode_e instr_op(input logic [INSTR_W-1:0] instr);
        return opcode_e'(instr[OPC_MSB:OPC_LSB]);
    endfunction

    function automatic logic [1:0] instr_rd(input logic [INSTR_W-1:0] instr);
        return instr[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [1:0] instr_rs(input logic [INSTR_W-1:0] instr);
        return instr[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [7:0] instr_imm(input logic [INSTR_W-1:0] instr);
        return instr[IMM_MSB:IMM_LSB];
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Bus between the sequencer (master) and the single-op ALU (slave).
interface alu_seq_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] alu_in1_o;
    logic [DATA_W-1:0] alu_in2_o;
    logic              alu_op_o;
    logic [DATA_W-1:0] alu_out_i;
    logic              alu_z_i;

    modport master (
        output alu_in1_o,
        output alu_in2_o,
        output alu_op_o,
        input  alu_out_i,
        input  alu_z_i
    );

    modport slave (
        input  alu_in1_o,
        input  alu_in2_o,
        input  alu_op_o,
        output alu_out_i,
        output alu_z_i
    );
endinterface

// File: rtl/alu_seq_regfile.sv
// 4-entry register file: one write port, three combinational read ports
// (two ALU operands plus host readback).
module alu_seq_regfile #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [1:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        raddr_a,
    input  logic [1:0]        raddr_b,
    input  logic [1:0]        raddr_c,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [DATA_W-1:0] rdata_c
);
    logic [DATA_W-1:0] regs [4];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];
    assign rdata_c = regs[raddr_c];

endmodule

// File: rtl/alu_seq.sv
// Micro-sequencer: fetches from a 1-cycle-latency ROM, runs LDI/ADD/JZ/HALT,
// and drives an external single-op ALU whose Z flag is registered.
//
// state    | meaning
// S_IDLE   | waiting for start_i; done_o may pulse here
// S_FETCH  | imem_addr_o = pc presented to the ROM
// S_DECODE | ROM word valid, latched into ir
// S_EXEC   | execute ir, update pc
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    alu_seq_if.master          alu,
    input  logic [1:0]         reg_sel_i,
    output logic [DATA_W-1:0]  reg_data_o
);
    state_e              state, state_next;
    logic [ADDR_W-1:0]   pc, pc_next;
    logic [INSTR_W-1:0]  ir, ir_next;
    logic                busy, done, done_next;
    logic                alu_op;
    logic                we;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   rd_data, rs_data;

    opcode_e             op;
    logic [1:0]          rd, rs;
    logic [7:0]          imm;
    logic                unused_ir;

    assign op  = instr_op(ir);
    assign rd  = instr_rd(ir);
    assign rs  = instr_rs(ir);
    assign imm = instr_imm(ir);
    assign unused_ir = ^ir[9:8];

    alu_seq_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset_i),
        .we      (we),
        .waddr   (rd),
        .wdata   (wdata),
        .raddr_a (rd),
        .raddr_b (rs),
        .raddr_c (reg_sel_i),
        .rdata_a (rd_data),
        .rdata_b (rs_data),
        .rdata_c (reg_data_o)
    );

    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        done_next  = 1'b0;
        we         = 1'b0;
        wdata      = DATA_W'(imm);
        alu_op     = 1'b0;

        case (state)
            S_IDLE: begin
                if (start_i) begin
                    pc_next    = RESET_PC;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_DECODE;
            end
            S_DECODE: begin
                ir_next    = imem_data_i;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                state_next = S_FETCH;
                pc_next    = pc + 1'b1;
                case (op)
                    OP_LDI: begin
                        we    = 1'b1;
                        wdata = DATA_W'(imm);
                    end
                    // ALU result is combinational, so rd is written in this same cycle
                    OP_ADD: begin
                        we     = 1'b1;
                        wdata  = alu.alu_out_i;
                        alu_op = ALU_OP_ADD;
                    end
                    OP_JZ: begin
                        if (alu.alu_z_i) begin
                            pc_next = ADDR_W'(imm);
                        end
                    end
                    OP_HALT: begin
                        pc_next    = pc;
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            ir    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            ir    <= ir_next;
            busy  <= (state_next != S_IDLE);
            done  <= done_next;
        end
    end

    assign imem_addr_o   = pc;
    assign busy_o        = busy;
    assign done_o        = done;
    assign alu.alu_op_o  = alu_op;
    assign alu.alu_in1_o = rd_data;
    assign alu.alu_in2_o = rs_data;

endmodule
